// File: rtl/uart_arb_pkg.sv
// Shared definitions for the multi-channel UART transmit arbiter:
// serialiser state encoding, channel tag nibble, default bit timing and a clog2 helper.
package uart_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [3:0] TAG_NIBBLE = 4'hA;

   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // Never returns less than 1 so single-value counters still get a real bit.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART serialiser: start bit, DATA_W data bits LSB first, STOP_BITS stop bits.
// A start request in the last stop cycle chains the next frame with no idle gap.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line high, waiting for start
// ST_START | line low for one bit time
// ST_DATA  | line = shift[0], one bit time per data bit
// ST_STOP  | line high for STOP_BITS bit times, done in last cycle
module uart_tx_core
   import uart_arb_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              tx,
   output logic              done
);

   localparam int TMR_W = clog2(CLKS_PER_BIT);
   localparam int IDX_W = clog2(DATA_W);
   localparam int STP_W = clog2(STOP_BITS);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [STP_W-1:0] STP_LAST = STP_W'(STOP_BITS - 1);

   logic [1:0]        state, state_n;
   logic [TMR_W-1:0]  timer, timer_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [STP_W-1:0]  stop_cnt, stop_n;
   logic [DATA_W-1:0] shift, shift_n;
   logic              tx_n;
   logic              bit_end;

   assign bit_end = (timer == TMR_LAST);

   always_comb begin
      state_n = state;
      timer_n = timer;
      idx_n   = idx;
      stop_n  = stop_cnt;
      shift_n = shift;
      done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_START;
               timer_n = '0;
               shift_n = data;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_n = ST_DATA;
               timer_n = '0;
               idx_n   = '0;
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               timer_n = '0;
               shift_n = shift >> 1;
               if (idx == IDX_LAST) begin
                  state_n = ST_STOP;
                  stop_n  = '0;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               timer_n = '0;
               if (stop_cnt == STP_LAST) begin
                  done = 1'b1;
                  if (start) begin
                     state_n = ST_START;
                     shift_n = data;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  stop_n = stop_cnt + STP_W'(1);
               end
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Line level is registered from the next state so the pin never glitches.
   always_comb begin
      case (state_n)
         ST_START: tx_n = 1'b0;
         ST_DATA:  tx_n = shift_n[0];
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         timer    <= '0;
         idx      <= '0;
         stop_cnt <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         idx      <= idx_n;
         stop_cnt <= stop_n;
         shift    <= shift_n;
         tx       <= tx_n;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NUM_CH valid/ready requesters onto one UART line.
// UART_ARB_CHANNEL_TAG_EN: each grant sends a {TAG_NIBBLE, grant_id} frame ahead of the data frame.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1,
   localparam int GID_W       = clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     tx,
   output logic                     busy,
   output logic [GID_W-1:0]         grant_id,
   output logic                     frame_done
);

   logic [GID_W-1:0]  ptr;
   logic [GID_W-1:0]  winner;
   logic              any_valid;
   logic              accept;
   logic [DATA_W-1:0] win_data;
   logic              core_start;
   logic [DATA_W-1:0] core_data;
   logic              core_done;

   // Scan downward so the lowest offset from the pointer is written last and wins.
   always_comb begin
      int idx;
      idx       = 0;
      winner    = ptr;
      any_valid = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_CH;
         if (ch_valid[idx]) begin
            winner    = GID_W'(idx);
            any_valid = 1'b1;
         end
      end
   end

   assign accept   = ~busy & any_valid & ~reset;
   assign ch_ready = accept ? (NUM_CH'(1) << winner) : '0;
   assign win_data = ch_data[winner*DATA_W +: DATA_W];

`ifdef UART_ARB_CHANNEL_TAG_EN
   logic              tag_phase;
   logic [DATA_W-1:0] word;
   logic [7:0]        tag_byte;

   assign tag_byte   = {TAG_NIBBLE, 4'(winner)};
   assign core_start = accept | (core_done & tag_phase);
   assign core_data  = accept ? DATA_W'(tag_byte) : word;
   assign frame_done = core_done & ~tag_phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_phase <= 1'b0;
         word      <= '0;
      end else if (accept) begin
         tag_phase <= 1'b1;
         word      <= win_data;
      end else if (core_done) begin
         tag_phase <= 1'b0;
      end
   end
`else
   assign core_start = accept;
   assign core_data  = win_data;
   assign frame_done = core_done;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         grant_id <= '0;
         ptr      <= '0;
      end else if (accept) begin
         busy     <= 1'b1;
         grant_id <= winner;
         ptr      <= (winner == GID_W'(NUM_CH - 1)) ? '0 : winner + GID_W'(1);
      end else if (frame_done) begin
         busy     <= 1'b0;
      end
   end

   uart_tx_core #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .STOP_BITS    (STOP_BITS)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .start (core_start),
      .data  (core_data),
      .tx    (tx),
      .done  (core_done)
   );

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Parametrised successor to the single-channel UART transmit arbiter.
- Accepts bytes from NUM_CH requesters over valid/ready handshakes and grants them round-robin.
- Serialises each granted word on one shared UART line: start bit, DATA_W data bits LSB first, STOP_BITS stop bits.
- Sits between the Nios custom-instruction/application logic and the board TX pin.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_W, 8, data bits per frame (5..9).
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ch_valid  input  NUM_CH  per-channel request; bit i set means ch_data slice i holds a word to send.
- ch_data  input  NUM_CH*DATA_W  packed words; channel i at [i*DATA_W +: DATA_W].
- ch_ready  output  NUM_CH  one-hot accept strobe; handshake completes when ch_valid[i] & ch_ready[i].
- tx  output  1  serial line, idle high.
- busy  output  1  high from the accept cycle's next edge until the end of the last stop bit.
- grant_id  output  clog2(NUM_CH)  index of the channel being transmitted; held while busy.
- frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit of a grant.

Behaviour:
- Reset values: tx=1, busy=0, ch_ready=0, grant_id=0, frame_done=0, FSM=IDLE, round-robin pointer=0 (channel 0 has highest priority first).
- FSM states: IDLE, START, DATA, STOP; plus TAG_* reuse (see Optional Feature).
- Bit timer counts 0..CLKS_PER_BIT-1; bit index counts 0..DATA_W-1; stop counter counts 0..STOP_BITS-1.
- IDLE:
  - ch_ready is combinational.
  - The winner is the first set ch_valid bit scanning upward from the pointer, wrapping at NUM_CH-1 -> 0.
  - ch_ready[winner]=1 in the same cycle; the word is captured on that edge.
  - Next cycle: state START, tx=0, busy=1, grant_id=winner, pointer=winner+1 mod NUM_CH.
- ch_ready is 0 in every state other than IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first; after bit DATA_W-1 go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses in the last cycle. Next state IDLE, busy=0.
- Minimum inter-frame gap: one idle cycle in IDLE, i.e. the stop period plus 1 clk.
- A channel dropping ch_valid before a grant is simply not selected. After acceptance, ch_data changes have no effect.
- Simultaneous requests from all channels are served 0,1,2,3,0,... with no starvation.
- A lone repeating requester is granted every frame.
- Reset asserted mid-frame: immediate return to reset values. tx goes high asynchronously and the partial frame is abandoned.
- Total frame length: (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.

Optional Feature:
- UART_ARB_CHANNEL_TAG_EN defined:
  - Each grant emits two back-to-back frames: first a tag frame with data = {4'hA, grant_id} truncated or zero-padded to DATA_W, then the data frame.
  - There is no idle cycle between the two frames.
  - frame_done pulses only after the data frame.
  - busy stays high across both frames.
  - Requires DATA_W >= 8.
- Undefined: single data frame per grant, exactly as above.

Decomposition:
- Shared package uart_arb_pkg holds:
  - the FSM state encoding;
  - the TAG_NIBBLE constant 4'hA;
  - the default CLKS_PER_BIT constant;
  - a clog2 helper function.
- One natural sub-module, uart_tx_core: serialiser with DATA_W, CLKS_PER_BIT and STOP_BITS parameters, plus start/data/done ports.
- uart_tx_arbiter keeps the round-robin pointer, handshake and grant registers, and sequences uart_tx_core (twice per grant when the tag feature is on).

Test Plan (CLKS_PER_BIT=4, NUM_CH=4, DATA_W=8, STOP_BITS=1 unless stated):
1. Reset then idle -> tx=1, busy=0, ch_ready=0 for 100 cycles; ch_valid=0.
2. ch_valid=4'b0100, slice 2 = 8'hA5 -> ch_ready=4'b0100 for 1 cycle. Then tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles. grant_id=2; frame_done pulses at cycle 40 after accept.
3. ch_valid=4'b1111 held, data = 8'h11/22/33/44 -> frames 11,22,33,44,11 in order. grant_id sequence 0,1,2,3,0; each gap between frames is 1 idle cycle.
4. STOP_BITS=2, single send of 8'hFF -> stop high for 8 cycles; frame is 44 cycles long.
5. Reset asserted at cycle 15 of a frame -> tx=1 immediately; busy=0; the next grant restarts from channel 0.
6. UART_ARB_CHANNEL_TAG_EN, ch_valid=4'b0010, data 8'h3C -> frame 8'hA1 immediately followed by frame 8'h3C. busy is continuous; one frame_done pulse.
